requant_pipe: RTL
=================

REQUANT_PIPE -- requirements
Module: requant_pipe

Interface
REQ-001 SHALL take parameter DATAIN_WIDTH, default 14: signed accumulator width per channel.
REQ-002 SHALL take parameter DATAOUT_WIDTH, default 8: signed activation width per channel.
REQ-003 SHALL take parameter NUM_CH, default 4: parallel channels per beat.
REQ-004 SHALL take parameter MULT_WIDTH, default 8: unsigned per-channel scale width.
REQ-005 SHALL take parameter SHIFT_WIDTH, default 5: per-channel right-shift width.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port CLOCK_50, input, 1 bit: sole clock, rising edge.
REQ-008 SHALL have port RESET_InLow, input, 1 bit: async active-low reset.
REQ-009 SHALL have port Requant_InValid, input, 1 bit: input beat valid.
REQ-010 SHALL have port Requant_InReady, output, 1 bit: block accepts beat.
REQ-011 SHALL have port Requant_InBUS, input, NUM_CH*DATAIN_WIDTH bits: channel 0 in LSBs.
REQ-012 SHALL have port Requant_CfgWe, input, 1 bit: config write strobe.
REQ-013 SHALL have port Requant_CfgCh, input, clog2(NUM_CH) bits: channel index for the write.
REQ-014 SHALL have port Requant_CfgMult, input, MULT_WIDTH bits: scale value.
REQ-015 SHALL have port Requant_CfgShift, input, SHIFT_WIDTH bits: shift value.
REQ-016 SHALL have port Requant_Mode, input, 2 bits: bit0 round-half-up enable, bit1 ReLU enable.
REQ-017 SHALL have port Requant_OutValid, output, 1 bit: output beat valid.
REQ-018 SHALL have port Requant_OutReady, input, 1 bit: downstream accepts beat.
REQ-019 SHALL have port Requant_OutBUS, output, NUM_CH*DATAOUT_WIDTH bits: channel 0 in LSBs.
REQ-020 SHALL have port Requant_SatFlag, output, NUM_CH bits: per-channel saturation, aligned with Requant_OutBUS.
REQ-021 SHALL have port Requant_SatCount, output, 16 bits: count of saturated beats.
REQ-022 SHALL have port Requant_SatClr, input, 1 bit: synchronous counter clear.

Function
REQ-023 SHALL transfer an input beat when Requant_InValid and Requant_InReady are both high on a rising edge; output transfers likewise with Requant_OutValid/Requant_OutReady.
REQ-024 SHALL compute per channel y = (x*mult + rnd) >>> shift, with x signed, mult unsigned, full-precision product, and arithmetic shift.
REQ-025 SHALL set rnd = 2^(shift-1) when round is enabled and shift>0, else 0.
REQ-026 SHALL saturate y to [-2^(DATAOUT_WIDTH-1), 2^(DATAOUT_WIDTH-1)-1], or to [0, 2^(DATAOUT_WIDTH-1)-1] when ReLU is enabled; the SatFlag bit SHALL be 1 only when the clamp changed the value (ReLU zeroing is not saturation).
REQ-027 SHALL have a 2-stage pipeline (stage 1: multiply/round-add; stage 2: shift/clamp), giving latency 2 cycles from accept to OutValid with no stall.
REQ-028 SHALL drive Requant_InReady = NOT(Requant_OutValid AND NOT Requant_OutReady), a global stall; no bubbles SHALL be inserted; full throughput is 1 beat/cycle.
REQ-029 SHALL hold OutBUS/SatFlag stable while OutValid=1 and OutReady=0.
REQ-030 SHALL capture mult, shift and Mode into stage 1 with each beat; a config write or Mode change SHALL affect only beats accepted on later cycles.
REQ-031 SHALL make a config write in cycle N effective for a beat accepted in cycle N+1; a write in the same cycle as an accept SHALL not affect that beat.
REQ-032 SHALL ignore Requant_CfgCh values >= NUM_CH.
REQ-033 SHALL increment Requant_SatCount by 1 per output transfer with any SatFlag bit set, stop incrementing at 0xFFFF, and zero it on SatClr; SatClr SHALL win when both occur in the same cycle.

Reset
REQ-034 SHALL on RESET_InLow low, asynchronously: clear OutValid, OutBUS, SatFlag and SatCount; set mult=1 and shift=DATAIN_WIDTH-DATAOUT_WIDTH for every channel; and discard in-flight beats.
REQ-035 SHALL hold InReady=0 during reset, rising to 1 on the first edge after reset release.

Structure
REQ-036 SHALL place the width constants, Mode bit positions, SAT_COUNT_WIDTH=16, and reset mult/shift values in a shared package requant_pkg.
REQ-037 SHALL implement per-channel arithmetic in one sub-module, requant_lane, instantiated NUM_CH times; handshake, config and counter logic SHALL be in the top.

Verification
REQ-038 SHALL cover, after reset defaults with Mode=00: x=8191 -> 127, SatFlag=0; x=-8192 -> -128; x=100 -> 1, appearing 2 cycles after accept.
REQ-039 SHALL cover rounding with mult=1, shift=6: x=96 gives 1 with Mode=00 and 2 with Mode=01; x=-96 with Mode=01 gives -1.
REQ-040 SHALL cover saturation with mult=4, shift=6, x=4000 -> 127, SatFlag=1, SatCount=1; with Mode=10, x=-500 -> 0, SatFlag=0.
REQ-041 SHALL cover back-pressure: stream 8 beats, hold OutReady=0 for 5 cycles mid-stream -> InReady low, OutBUS held, all 8 beats arrive in order with none lost or duplicated.
REQ-042 SHALL cover a config write to channel 2 in the same cycle as an accept -> that beat uses old values and the next beat uses new values.
REQ-043 SHALL cover assertion of RESET_InLow with 2 beats in flight -> OutValid=0 immediately, and no stale beat appears after release.

Source files
------------

// File: rtl/requant_pkg.sv
`default_nettype none
// ============================================================================
// Module      : requant_pkg
// Description : Shared constants for the requantisation pipeline. Holds the
//               default widths, the Mode bit positions, the saturation counter
//               width, the mult/shift values loaded at reset and an
//               accumulator width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package requant_pkg;

  localparam int DATAIN_WIDTH_DEF  = 14;
  localparam int DATAOUT_WIDTH_DEF = 8;
  localparam int NUM_CH_DEF        = 4;
  localparam int MULT_WIDTH_DEF    = 8;
  localparam int SHIFT_WIDTH_DEF   = 5;

  localparam int MODE_RND_BIT      = 0;
  localparam int MODE_RELU_BIT     = 1;

  localparam int SAT_COUNT_WIDTH   = 16;

  localparam int RST_MULT          = 1;

  // Reset shift brings a full-scale input down to full-scale output.
  function automatic int rst_shift(input int din_w, input int dout_w);
    return din_w - dout_w;
  endfunction

  // The accumulator must hold the full product, one extra sign bit and also
  // the largest rounding constant 2^(2^SHIFT_WIDTH - 2), so big shifts with
  // rounding still give the exact result.
  function automatic int acc_width(input int din_w, input int mult_w, input int shift_w);
    int a;
    int b;
    a = din_w + mult_w + 2;
    b = (1 << shift_w) + 1;
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/requant_lane.sv
`default_nettype none
// ============================================================================
// Module      : requant_lane
// Description : One channel of the requantiser. Stage 1 forms x*mult + rnd,
//               stage 2 applies the arithmetic shift and the clamp. Both
//               stages advance together on en_i.
// Ports       : clk_i, rst_ni     - clock, async active-low reset
//               en_i              - pipeline advance
//               x_i               - signed input sample
//               mult_i, shift_i   - unsigned scale and right-shift
//               round_i, relu_i   - mode controls captured with the sample
//               y_o, sat_o        - clamped result and saturation flag
// Revision    : 1.0 - initial release
// ============================================================================
module requant_lane
  import requant_pkg::*;
#(
  parameter int DATAIN_WIDTH  = DATAIN_WIDTH_DEF,
  parameter int DATAOUT_WIDTH = DATAOUT_WIDTH_DEF,
  parameter int MULT_WIDTH    = MULT_WIDTH_DEF,
  parameter int SHIFT_WIDTH   = SHIFT_WIDTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic [DATAIN_WIDTH-1:0]  x_i,
  input  logic [MULT_WIDTH-1:0]    mult_i,
  input  logic [SHIFT_WIDTH-1:0]   shift_i,
  input  logic                     round_i,
  input  logic                     relu_i,
  output logic [DATAOUT_WIDTH-1:0] y_o,
  output logic                     sat_o
);

  localparam int ACC_W  = acc_width(DATAIN_WIDTH, MULT_WIDTH, SHIFT_WIDTH);
  localparam int HI_INT = (1 << (DATAOUT_WIDTH - 1)) - 1;
  localparam logic signed [ACC_W-1:0] C_HI = ACC_W'(HI_INT);
  localparam logic signed [ACC_W-1:0] C_LO = ACC_W'(-HI_INT - 1);

  // Stage 1: multiply and add the rounding constant
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] m_ext;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] acc_d;

  logic signed [ACC_W-1:0] acc_q;
  logic [SHIFT_WIDTH-1:0]  shift_q;
  logic                    relu_q;

  always_comb begin
    x_ext = {{(ACC_W - DATAIN_WIDTH){x_i[DATAIN_WIDTH-1]}}, x_i};
    m_ext = {{(ACC_W - MULT_WIDTH){1'b0}}, mult_i};
    rnd   = '0;
    if (round_i && (shift_i != '0)) begin
      rnd = ACC_W'(1) << (shift_i - SHIFT_WIDTH'(1));
    end
    acc_d = (x_ext * m_ext) + rnd;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if (en_i) begin
      acc_q   <= acc_d;
      shift_q <= shift_i;
      relu_q  <= relu_i;
    end
  end

  // Stage 2: shift and clamp. Negative values zeroed by ReLU are not
  // reported as saturation.
  logic signed [ACC_W-1:0]   shifted;
  logic [DATAOUT_WIDTH-1:0]  y_d;
  logic                      sat_d;
  logic [DATAOUT_WIDTH-1:0]  y_q;
  logic                      sat_q;

  always_comb begin
    shifted = acc_q >>> shift_q;
    y_d     = DATAOUT_WIDTH'(shifted);
    sat_d   = 1'b0;
    if (shifted > C_HI) begin
      y_d   = DATAOUT_WIDTH'(C_HI);
      sat_d = 1'b1;
    end else if (relu_q && shifted[ACC_W-1]) begin
      y_d   = '0;
    end else if (shifted < C_LO) begin
      y_d   = DATAOUT_WIDTH'(C_LO);
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_q   <= '0;
      sat_q <= 1'b0;
    end else if (en_i) begin
      y_q   <= y_d;
      sat_q <= sat_d;
    end
  end

  assign y_o   = y_q;
  assign sat_o = sat_q;

endmodule
`default_nettype wire

// File: rtl/requant_pipe.sv
`default_nettype none
// ============================================================================
// Module      : requant_pipe
// Description : Multi-channel requantiser: y = clamp((x*mult + rnd) >>> shift)
//               with a 2-stage valid/ready pipeline, per-channel scale/shift
//               registers and a saturating count of saturated output beats.
// Ports       : CLOCK_50, RESET_InLow          - clock, async active-low reset
//               Requant_In*                    - input beat handshake + data
//               Requant_Cfg*                   - per-channel mult/shift write
//               Requant_Mode                   - bit0 rounding, bit1 ReLU
//               Requant_Out*, Requant_SatFlag  - output beat handshake + data
//               Requant_SatCount/SatClr        - saturated-beat counter
// Revision    : 1.0 - initial release
// ============================================================================
module requant_pipe
  import requant_pkg::*;
#(
  parameter int DATAIN_WIDTH  = DATAIN_WIDTH_DEF,
  parameter int DATAOUT_WIDTH = DATAOUT_WIDTH_DEF,
  parameter int NUM_CH        = NUM_CH_DEF,
  parameter int MULT_WIDTH    = MULT_WIDTH_DEF,
  parameter int SHIFT_WIDTH   = SHIFT_WIDTH_DEF
) (
  input  logic                              CLOCK_50,
  input  logic                              RESET_InLow,
  input  logic                              Requant_InValid,
  output logic                              Requant_InReady,
  input  logic [NUM_CH*DATAIN_WIDTH-1:0]    Requant_InBUS,
  input  logic                              Requant_CfgWe,
  input  logic [$clog2(NUM_CH)-1:0]         Requant_CfgCh,
  input  logic [MULT_WIDTH-1:0]             Requant_CfgMult,
  input  logic [SHIFT_WIDTH-1:0]            Requant_CfgShift,
  input  logic [1:0]                        Requant_Mode,
  output logic                              Requant_OutValid,
  input  logic                              Requant_OutReady,
  output logic [NUM_CH*DATAOUT_WIDTH-1:0]   Requant_OutBUS,
  output logic [NUM_CH-1:0]                 Requant_SatFlag,
  output logic [SAT_COUNT_WIDTH-1:0]        Requant_SatCount,
  input  logic                              Requant_SatClr
);

  localparam logic [MULT_WIDTH-1:0]  C_RST_MULT  = MULT_WIDTH'(RST_MULT);
  localparam logic [SHIFT_WIDTH-1:0] C_RST_SHIFT =
    SHIFT_WIDTH'(rst_shift(DATAIN_WIDTH, DATAOUT_WIDTH));

  // Ready is held low until the first edge after reset release.
  logic ready_en_q;
  logic v1_q;
  logic out_valid_q;
  logic adv;

  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) ready_en_q <= 1'b0;
    else              ready_en_q <= 1'b1;
  end

  // One global stall: every stage moves only when the output register is
  // free or being emptied, so no bubbles are ever created.
  assign Requant_InReady = ready_en_q & ~(out_valid_q & ~Requant_OutReady);
  assign adv             = Requant_InReady;

  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      v1_q        <= Requant_InValid;
      out_valid_q <= v1_q;
    end
  end

  assign Requant_OutValid = out_valid_q;

  // Per-channel configuration. A write lands on the same edge that captures
  // a concurrently accepted beat, so that beat still sees the old values.
  logic [MULT_WIDTH-1:0]  mult_q  [NUM_CH];
  logic [SHIFT_WIDTH-1:0] shift_q [NUM_CH];

  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mult_q[i]  <= C_RST_MULT;
        shift_q[i] <= C_RST_SHIFT;
      end
    end else if (Requant_CfgWe && (int'(Requant_CfgCh) < NUM_CH)) begin
      mult_q[Requant_CfgCh]  <= Requant_CfgMult;
      shift_q[Requant_CfgCh] <= Requant_CfgShift;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    requant_lane #(
      .DATAIN_WIDTH  (DATAIN_WIDTH),
      .DATAOUT_WIDTH (DATAOUT_WIDTH),
      .MULT_WIDTH    (MULT_WIDTH),
      .SHIFT_WIDTH   (SHIFT_WIDTH)
    ) u_lane (
      .clk_i   (CLOCK_50),
      .rst_ni  (RESET_InLow),
      .en_i    (adv),
      .x_i     (Requant_InBUS[c*DATAIN_WIDTH +: DATAIN_WIDTH]),
      .mult_i  (mult_q[c]),
      .shift_i (shift_q[c]),
      .round_i (Requant_Mode[MODE_RND_BIT]),
      .relu_i  (Requant_Mode[MODE_RELU_BIT]),
      .y_o     (Requant_OutBUS[c*DATAOUT_WIDTH +: DATAOUT_WIDTH]),
      .sat_o   (Requant_SatFlag[c])
    );
  end

  // Saturated-beat counter: sticks at all-ones, clear has priority.
  logic [SAT_COUNT_WIDTH-1:0] sat_cnt_d;
  logic [SAT_COUNT_WIDTH-1:0] sat_cnt_q;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (Requant_SatClr) begin
      sat_cnt_d = '0;
    end else if (out_valid_q && Requant_OutReady && (|Requant_SatFlag) &&
                 (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) sat_cnt_q <= '0;
    else              sat_cnt_q <= sat_cnt_d;
  end

  assign Requant_SatCount = sat_cnt_q;

endmodule
`default_nettype wire
